// File: rtl/vga_fetch_pkg.sv
// Shared constants and FSM encoding for the VGA line prefetcher.
// Imported by the line buffer and the fetch controller.
package vga_fetch_pkg;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int WORDS_PER_LINE = H_ACTIVE / 4;
    localparam int PIX_W          = 8;
    localparam int WC_W           = $clog2(WORDS_PER_LINE);
    localparam int PIX_IDX_W      = $clog2(H_ACTIVE);

    typedef enum logic {
        IDLE,
        FETCH
    } fetch_state_e;

endpackage

// File: rtl/vga_line_fetch_if.sv
// Word-wide framebuffer read bus: req/ack with same-cycle read data.
// Master holds the address stable while mem_req is high.
interface vga_line_fetch_if #(
    parameter int ADDR_W = 17
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/line_buffer_2bank.sv
// Two-bank line buffer: 4-pixel synchronous write, 1-pixel async read.
// Holds the per-bank valid flags driven by the fetch controller.
module line_buffer_2bank
    import vga_fetch_pkg::*;
(
    input  logic                 c25,
    input  logic                 Reset,
    input  logic                 we,
    input  logic                 wbank,
    input  logic [WC_W-1:0]      widx,
    input  logic [31:0]          wdata,
    input  logic                 rbank,
    input  logic [PIX_IDX_W-1:0] ridx,
    output logic [PIX_W-1:0]     rdata,
    input  logic                 clr_v,
    input  logic                 clr_bank,
    input  logic                 set_v,
    input  logic                 set_bank,
    output logic [1:0]           valid
);

    logic [PIX_W-1:0] mem [2][H_ACTIVE];

    always_ff @(posedge c25) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                mem[wbank][{widx, 2'(k)}] <= wdata[PIX_W*k +: PIX_W];
            end
        end
    end

    assign rdata = mem[rbank][ridx];

    always_ff @(posedge c25 or negedge Reset) begin
        if (!Reset) begin
            valid <= '0;
        end else begin
            if (clr_v) valid[clr_bank] <= 1'b0;
            if (set_v) valid[set_bank] <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_line_fetch.sv
// Prefetches the next display line into the idle bank of a ping-pong
// buffer and serves pixels combinationally to the VGA timing stage.
module vga_line_fetch
    import vga_fetch_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter int BASE_ADDR = 0
) (
    input  logic               c25,
    input  logic               Reset,
    input  logic [9:0]         row_in,
    input  logic [9:0]         col_in,
    output logic [PIX_W-1:0]   pixel_out,
    output logic               underrun,
    input  logic               underrun_clr,
    vga_line_fetch_if.master   mem
);

    localparam logic [9:0]      V_END   = 10'(V_ACTIVE);
    localparam logic [9:0]      H_END   = 10'(H_ACTIVE);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_LINE - 1);

    fetch_state_e      state;
    logic [WC_W-1:0]   word_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;
    logic              target;
    logic [9:0]        prev_row;

    logic              trig, fetch_go, abort, wr_en, last;
    logic              active, disp_bank, disp_ur;
    logic [ADDR_W-1:0] line_base;
    logic [9:0]        rd_idx;
    logic [PIX_W-1:0]  rdata;
    logic [1:0]        valid;

    assign trig      = prev_row != row_in;
    assign fetch_go  = trig && (row_in < V_END);
    assign abort     = trig && (state == FETCH);
    assign last      = word_cnt == WC_LAST;
    assign wr_en     = (state == FETCH) && mem.mem_ack && !trig;
    assign line_base = ADDR_W'(BASE_ADDR)
                     + ADDR_W'(row_in) * ADDR_W'(WORDS_PER_LINE);

    // (row_in-1)[0] is simply the inverse of row_in[0]
    assign disp_bank = ~row_in[0];
    assign active    = (row_in != '0) && (row_in <= V_END)
                    && (col_in != '0) && (col_in <= H_END);
    assign rd_idx    = active ? col_in - 10'd1 : '0;
    assign disp_ur   = active && !valid[disp_bank];
    assign pixel_out = (active && valid[disp_bank]) ? rdata : '0;

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;

    always_ff @(posedge c25 or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            target   <= 1'b0;
            underrun <= 1'b0;
            prev_row <= 10'h3FF;
        end else begin
            prev_row <= row_in;
            if (abort || disp_ur) underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
            if (abort && !fetch_go) begin
                req_q <= 1'b0;
                state <= IDLE;
            end else if (fetch_go) begin
                target   <= row_in[0];
                word_cnt <= '0;
                addr_q   <= line_base;
                req_q    <= 1'b1;
                state    <= FETCH;
            end else if (wr_en) begin
                if (last) begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    addr_q   <= addr_q + 1'b1;
                end
            end
        end
    end

    line_buffer_2bank u_buf (
        .c25      (c25),
        .Reset    (Reset),
        .we       (wr_en),
        .wbank    (target),
        .widx     (word_cnt),
        .wdata    (mem.mem_rdata),
        .rbank    (disp_bank),
        .ridx     (rd_idx),
        .rdata    (rdata),
        .clr_v    (fetch_go),
        .clr_bank (row_in[0]),
        .set_v    (wr_en && last),
        .set_bank (target),
        .valid    (valid)
    );

endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch: memory model with address scoreboard,
// pixel vector table and hand-written abort/reset/underrun sequences.
module tb_vga_line_fetch;

    logic       c25 = 1'b0;
    logic       Reset;
    logic [9:0] row_in, col_in;
    logic [7:0] pixel_out;
    logic       underrun, underrun_clr;

    int n_total = 0;
    int n_pass  = 0;
    int hs_cnt  = 0;
    int ack_mode = 1;
    int dly = 0;
    logic pend = 1'b0;
    logic [16:0] held = '0;
    logic [16:0] exp_q[$];

    vga_line_fetch_if #(.ADDR_W(17)) mem_bus ();

    vga_line_fetch #(.ADDR_W(17), .BASE_ADDR(0)) dut (
        .c25          (c25),
        .Reset        (Reset),
        .row_in       (row_in),
        .col_in       (col_in),
        .pixel_out    (pixel_out),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .mem          (mem_bus)
    );

    always #5 c25 = ~c25;

    function automatic logic [31:0] fb_word(input logic [16:0] a);
        return 32'hDDCCBBAA ^ (32'(a) * 32'h9E3779B1);
    endfunction

    function automatic logic [7:0] exp_pix(input int line, input int p);
        logic [31:0] w;
        w = fb_word(17'(line * 160 + p / 4));
        return w[8*(p%4) +: 8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge c25);
        #1;
    endtask

    task automatic push_line(input int line);
        for (int w = 0; w < 160; w++) exp_q.push_back(17'(line * 160 + w));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1000; i++) begin
            if (!mem_bus.mem_req) break;
            tick();
        end
        chk("fetch_done", 32'(mem_bus.mem_req), 0);
    endtask

    // memory model: decides ack at the falling edge, DUT takes it at rise
    always @(negedge c25) begin
        logic ack;
        ack = 1'b0;
        mem_bus.mem_rdata = fb_word(mem_bus.mem_addr);
        if (ack_mode == 1) begin
            ack = 1'b1;
        end else if (ack_mode == 2 && mem_bus.mem_req) begin
            if (dly == 0) begin
                ack = 1'b1;
                dly = $urandom_range(0, 5);
            end else begin
                dly--;
            end
        end
        mem_bus.mem_ack = ack;
        if (ack_mode == 2 && pend && mem_bus.mem_req)
            chk("addr_hold", 32'(mem_bus.mem_addr), 32'(held));
        pend = mem_bus.mem_req && !ack;
        held = mem_bus.mem_addr;
        if (mem_bus.mem_req && ack) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: ack at %0h, none expected",
                         mem_bus.mem_addr);
            end else begin
                chk("sb_addr", 32'(mem_bus.mem_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic [9:0] col;
        logic [7:0] px;
    } vec_t;

    vec_t vecs[11];

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        Reset        = 1'b0;
        row_in       = 10'd1;
        col_in       = 10'd1;
        underrun_clr = 1'b0;

        vecs[0]  = '{10'd1,    8'hAA};
        vecs[1]  = '{10'd2,    8'hBB};
        vecs[2]  = '{10'd3,    8'hCC};
        vecs[3]  = '{10'd4,    8'hDD};
        vecs[4]  = '{10'd0,    8'h00};
        vecs[5]  = '{10'd641,  8'h00};
        vecs[6]  = '{10'd1023, 8'h00};
        vecs[7]  = '{10'd5,    exp_pix(0, 4)};
        vecs[8]  = '{10'd321,  exp_pix(0, 320)};
        vecs[9]  = '{10'd640,  exp_pix(0, 639)};
        vecs[10] = '{10'd160,  exp_pix(0, 159)};

        repeat (3) tick();
        chk("rst_req",   32'(mem_bus.mem_req),  0);
        chk("rst_addr",  32'(mem_bus.mem_addr), 0);
        chk("rst_ur",    32'(underrun),         0);
        chk("rst_pixel", 32'(pixel_out),        0);

        // line 0 right after reset release
        row_in = 10'd0;
        col_in = 10'd0;
        push_line(0);
        hs_cnt = 0;
        tick();
        Reset = 1'b1;
        tick();
        chk("l0_req_rise", 32'(mem_bus.mem_req),  1);
        chk("l0_addr0",    32'(mem_bus.mem_addr), 0);
        wait_done();
        chk("l0_acks",  hs_cnt, 160);
        chk("l0_drain", exp_q.size(), 0);

        // line 1 into bank 1 while line 0 is displayed
        row_in = 10'd1;
        push_line(1);
        hs_cnt = 0;
        tick();
        chk("l1_req",  32'(mem_bus.mem_req),  1);
        chk("l1_addr", 32'(mem_bus.mem_addr), 160);
        wait_done();
        chk("l1_acks",  hs_cnt, 160);
        chk("l1_drain", exp_q.size(), 0);
        foreach (vecs[i]) begin
            col_in = vecs[i].col;
            #1;
            chk($sformatf("vec%0d_col%0d", i, vecs[i].col),
                32'(pixel_out), 32'(vecs[i].px));
        end
        tick();
        chk("l1_no_ur", 32'(underrun), 0);

        // line 2 into bank 0 with random ack delay; line 1 stays shown
        ack_mode = 2;
        row_in = 10'd2;
        push_line(2);
        hs_cnt = 0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                int c;
                tick();
                c = $urandom_range(1, 640);
                col_in = 10'(c);
                #1;
                chk("l1_keep", 32'(pixel_out), 32'(exp_pix(1, c - 1)));
                if (mem_bus.mem_req) seen = 1'b1;
                else if (seen) break;
            end
        end
        chk("l2_done",  32'(mem_bus.mem_req), 0);
        chk("l2_acks",  hs_cnt, 160);
        chk("l2_drain", exp_q.size(), 0);
        chk("l2_no_ur", 32'(underrun), 0);

        // stalled fetch of line 3, then row change aborts it
        ack_mode = 0;
        row_in = 10'd3;
        col_in = 10'd5;
        #1;
        chk("l2_shown", 32'(pixel_out), 32'(exp_pix(2, 4)));
        repeat (3) tick();
        chk("l3_req",  32'(mem_bus.mem_req),  1);
        chk("l3_addr", 32'(mem_bus.mem_addr), 480);
        chk("l3_no_ur", 32'(underrun), 0);
        col_in = 10'd0;
        row_in = 10'd4;
        tick();
        chk("abort_ur",   32'(underrun),         1);
        chk("abort_req",  32'(mem_bus.mem_req),  1);
        chk("abort_addr", 32'(mem_bus.mem_addr), 640);
        col_in = 10'd10;
        #1;
        chk("abort_pixel", 32'(pixel_out), 0);
        col_in = 10'd0;

        // sticky flag: clear alone, then clear racing a new set
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("ur_clr", 32'(underrun), 0);
        underrun_clr = 1'b1;
        col_in = 10'd10;
        tick();
        underrun_clr = 1'b0;
        col_in = 10'd0;
        chk("ur_set_wins", 32'(underrun), 1);
        tick();
        chk("ur_sticky", 32'(underrun), 1);

        // reset in the middle of the line-4 fetch
        exp_q.delete();
        push_line(4);
        hs_cnt = 0;
        ack_mode = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (hs_cnt >= 50) break;
        end
        chk("mid_hs", hs_cnt, 50);
        Reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_bus.mem_req), 0);
        chk("mid_rst_ur",  32'(underrun),        0);
        row_in = 10'd0;
        tick();
        tick();
        exp_q.delete();
        push_line(0);
        hs_cnt = 0;
        Reset = 1'b1;
        tick();
        chk("re_req",  32'(mem_bus.mem_req),  1);
        chk("re_addr", 32'(mem_bus.mem_addr), 0);
        wait_done();
        chk("re_acks",  hs_cnt, 160);
        chk("re_drain", exp_q.size(), 0);
        ack_mode = 0;
        row_in = 10'd1;
        col_in = 10'd4;
        #1;
        chk("re_pixel", 32'(pixel_out), 32'h0000_00DD);
        tick();
        chk("end_no_ur", 32'(underrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
